alu16_reg: RTL and testbench

- 16-bit, 8-operation ALU with carry/borrow input, and zero and negative flags.
- The combinational datapath is registered once, so result and flags update on the rising clock edge.
- Used as the arithmetic/logic execution unit of the datapath. Fed directly from operand registers; result and flags go to writeback and branch logic.

---
 rtl/alu16_reg_if.sv | 39 +++
 rtl/alu16_reg.sv | 78 +++++++
 tb/tb_alu16_reg.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu16_reg_if.sv
// alu16_reg_if: operand/result bundle for the registered ALU.
//
// Signals:
//   a, b  operands (WIDTH bits)
//   cin   carry-in / borrow-in / shift-in bit
//   op    operation select (3 bits)
//   w     registered result (WIDTH bits)
//   zero  registered flag, 1 when w == 0
//   neg   registered flag, copy of the MSB of w
//
// Modports:
//   master  drives the operands and op, receives the result and flags.
//   slave   the ALU side: receives the operands, drives the result and flags.
//
// Timing contract: there is no valid/ready pair. Every rising clock edge is
// an accepted transfer: the master's operands at that edge are consumed, and
// the matching result and flags are presented after that same edge. They are
// held until the next edge.
interface alu16_reg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [2:0]       op;
    logic [WIDTH-1:0] w;
    logic             zero;
    logic             neg;

    modport master (
        output a, b, cin, op,
        input  w, zero, neg
    );

    modport slave (
        input  a, b, cin, op,
        output w, zero, neg
    );
endinterface

// File: rtl/alu16_reg.sv
// alu16_reg: 8-operation ALU whose result and zero/negative flags are
// registered once, giving a fixed latency of one clock and full throughput.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (w=0, zero=1, neg=0)
//   bus   alu16_reg_if.slave: a, b, cin, op in; w, zero, neg out
//
// Operations (arithmetic modulo 2^WIDTH, carry/borrow out discarded):
//   000 ADD a + b + cin        100 XOR a ^ b
//   001 SUB a - b - cin        101 NOT ~a
//   010 AND a & b              110 SHL {a[MSB-1:0], cin}
//   011 OR  a | b              111 SHR {cin, a[MSB:1]}
module alu16_reg #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu16_reg_if.slave    bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic             is_sub;
    logic [WIDTH-1:0] add_b;
    logic             add_c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;

    logic [WIDTH-1:0] w_q;
    logic             zero_q;
    logic             neg_q;

    // One adder serves ADD and SUB: a - b - cin == a + ~b + ~cin (mod 2^WIDTH).
    assign is_sub = (bus.op == OP_SUB);
    assign add_b  = is_sub ? ~bus.b   : bus.b;
    assign add_c  = is_sub ? ~bus.cin : bus.cin;
    assign sum    = bus.a + add_b + {{(WIDTH-1){1'b0}}, add_c};

    always_comb begin
        r = '0;
        unique case (bus.op)
            OP_ADD,
            OP_SUB: r = sum;
            OP_AND: r = bus.a & bus.b;
            OP_OR:  r = bus.a | bus.b;
            OP_XOR: r = bus.a ^ bus.b;
            OP_NOT: r = ~bus.a;
            OP_SHL: r = {bus.a[WIDTH-2:0], bus.cin};
            OP_SHR: r = {bus.cin, bus.a[WIDTH-1:1]};
            default: r = '0;
        endcase
    end

    // Flags are taken from the combinational result so they land on the
    // same edge as the value they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q    <= '0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
        end else begin
            w_q    <= r;
            zero_q <= (r == '0);
            neg_q  <= r[WIDTH-1];
        end
    end

    assign bus.w    = w_q;
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
endmodule

// File: tb/tb_alu16_reg.sv
module tb_alu16_reg;
    localparam int WIDTH = 16;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    alu16_reg_if #(.WIDTH(WIDTH)) bus ();

    alu16_reg #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Straight from the operation table using integer arithmetic and a mask.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin,
                                                input logic [2:0] op);
        longint mask;
        longint ia;
        longint ib;
        longint ic;
        longint res;
        mask = (longint'(1) << WIDTH) - 1;
        ia = longint'(a);
        ib = longint'(b);
        ic = longint'(cin);
        case (op)
            3'd0: res = ia + ib + ic;
            3'd1: res = ia - ib - ic;
            3'd2: res = ia & ib;
            3'd3: res = ia | ib;
            3'd4: res = ia ^ ib;
            3'd5: res = ~ia;
            3'd6: res = (ia * 2) + ic;
            default: res = (ia / 2) + (ic << (WIDTH - 1));
        endcase
        return WIDTH'(res & mask);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin,
                         input logic [2:0] op);
        rst     = r;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        bus.op  = op;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_out(input string tag);
        logic [WIDTH-1:0] ew;
        logic ez;
        logic en;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: expected queue empty", tag);
            return;
        end
        ew = exp_q.pop_front();
        ez = (ew == '0);
        en = ew[WIDTH-1];
        checks++;
        assert (bus.w === ew) else begin
            errors++;
            $error("FAIL %s w: got %h expected %h", tag, bus.w, ew);
        end
        checks++;
        assert (bus.zero === ez) else begin
            errors++;
            $error("FAIL %s zero: got %b expected %b", tag, bus.zero, ez);
        end
        checks++;
        assert (bus.neg === en) else begin
            errors++;
            $error("FAIL %s neg: got %b expected %b", tag, bus.neg, en);
        end
    endtask

    // One directed step with a literal expected result.
    task automatic step(input string tag, input logic r,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [2:0] op,
                        input logic [WIDTH-1:0] ew);
        drive(r, a, b, cin, op);
        exp_q.push_back(ew);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rc;
        logic [2:0] rop;
        logic [WIDTH-1:0] held;

        drive(1'b1, '0, '0, 1'b0, 3'd0);
        @(negedge clk);

        // Reset and release
        step("reset",      1'b1, 16'h1234, 16'h5678, 1'b0, 3'd0, 16'h0000);
        step("post_reset", 1'b0, 16'h1234, 16'h5678, 1'b0, 3'd0, 16'h68AC);

        // Arithmetic boundaries
        step("add_wrap",   1'b0, 16'hFFFF, 16'h0001, 1'b0, 3'd0, 16'h0000);
        step("add_cin",    1'b0, 16'h7FFF, 16'h0000, 1'b1, 3'd0, 16'h8000);
        step("sub_wrap",   1'b0, 16'h0000, 16'h0001, 1'b0, 3'd1, 16'hFFFF);
        step("sub_borrow", 1'b0, 16'h0005, 16'h0003, 1'b1, 3'd1, 16'h0001);

        // Logic ops; cin set to show it is ignored
        step("and", 1'b0, 16'hF0F0, 16'hFF00, 1'b1, 3'd2, 16'hF000);
        step("or",  1'b0, 16'hF0F0, 16'hFF00, 1'b1, 3'd3, 16'hFFF0);
        step("xor", 1'b0, 16'hF0F0, 16'hFF00, 1'b1, 3'd4, 16'h0FF0);
        step("not", 1'b0, 16'hF0F0, 16'hFF00, 1'b1, 3'd5, 16'h0F0F);

        // Shifts; b set to show it is ignored
        step("shl",     1'b0, 16'h8001, 16'hABCD, 1'b1, 3'd6, 16'h0003);
        step("shr",     1'b0, 16'h8001, 16'hABCD, 1'b0, 3'd7, 16'h4000);
        step("shr_cin", 1'b0, 16'h0001, 16'hABCD, 1'b1, 3'd7, 16'h8000);

        // Throughput: op changes every cycle; outputs must hold while inputs move
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 16'h1234, 16'h5678, 1'b0, 3'(k));
            exp_q.push_back(model(16'h1234, 16'h5678, 1'b0, 3'(k)));
            @(posedge clk);
            #1;
            held = exp_q[0];
            check_out($sformatf("thru_op%0d", k));
            drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 3'((k + 3) % 8));
            @(negedge clk);
            checks++;
            assert (bus.w === held) else begin
                errors++;
                $error("FAIL thru_hold%0d: got %h expected %h", k, bus.w, held);
            end
        end

        // Random vectors with a one-cycle reset mid-stream
        for (int i = 0; i < 1000; i++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rc  = 1'($urandom_range(0, 1));
            rop = 3'($urandom_range(0, 7));
            if (i == 500) begin
                drive(1'b1, ra, rb, rc, rop);
                exp_q.push_back('0);
            end else begin
                drive(1'b0, ra, rb, rc, rop);
                exp_q.push_back(model(ra, rb, rc, rop));
            end
            @(posedge clk);
            #1;
            check_out(i == 500 ? "mid_reset" : $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
